// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, WIDTH-bit a + b + ci, computed LSB-first
// through a single full-adder cell at one bit per clock.
//
// Handshake:
// - start is accepted in IDLE.
// - busy stays high while the operation is in flight.
// - done pulses for one cycle, in the same cycle that new s/co appear.
// - s/co hold their value until the next completed operation.
//
// Optional feature (macro SERIAL_ADDER_SUB_EN), which adds ports sub and ov:
// - sub=1 computes a-b in two's complement: b is inverted and the carry is forced to 1.
// - ov reports signed overflow.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; operands are latched on an accepted start
//   SHIFT | one result bit per cycle, exactly WIDTH cycles
//   DONE  | done high for one cycle; s/co already hold the new result
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
    output logic             ov,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_sh_nxt;
    logic             carry;
    logic             carry_nxt;
    logic             sum_bit;
    logic [CW-1:0]    count;
    logic             last_bit;

    // Single full-adder cell plus the sum shift-in.
    // The sum bit enters at the MSB, so after WIDTH shifts bit 0 ends up in s_sh[0].
    always_comb begin
        sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        s_sh_nxt  = s_sh >> 1;
        s_sh_nxt[WIDTH-1] = sum_bit;
        last_bit  = (count == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded directly from the state register.
    // done is therefore high for exactly the one DONE cycle.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Operand latch, serial datapath and result registers.
    // The result is written on the edge that enters DONE, so it appears together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            s     <= '0;
            co    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ov    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        count <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : ci;
`else
                        b_sh  <= b;
                        carry <= ci;
`endif
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_sh_nxt;
                    carry <= carry_nxt;
                    count <= count + CW'(1);
                    if (last_bit) begin
                        s  <= s_sh_nxt;
                        co <= carry_nxt;
`ifdef SERIAL_ADDER_SUB_EN
                        // On the last bit, carry is the carry into the MSB.
                        ov <= carry ^ carry_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8).
// A cycle-counting reference model predicts busy/done/s/co (and ov when
// SERIAL_ADDER_SUB_EN is defined) from plain arithmetic; a compare process
// checks every cycle, and directed cases pin the model with literal values.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
    logic         ov;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
        .ov    (ov),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model.
    // An accepted start keeps the adder busy for W+1 cycles, and the last of
    // those cycles carries done and the new result.
    int           m_rem = 0;
    logic [W-1:0] m_s   = '0;
    logic         m_co  = 1'b0;
    logic         m_ov  = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] p_s;
    logic         p_co;
    logic         p_ov;

    always @(posedge clk) begin
        logic [W-1:0] bb;
        logic         cin;
        if (rst) begin
            m_rem  = 0;
            m_s    = '0;
            m_co   = 1'b0;
            m_ov   = 1'b0;
            m_done = 1'b0;
        end else if (m_rem == 0) begin
            m_done = 1'b0;
            if (start) begin
                bb  = b;
                cin = ci;
`ifdef SERIAL_ADDER_SUB_EN
                if (sub) begin
                    bb  = ~b;
                    cin = 1'b1;
                end
`endif
                {p_co, p_s} = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
                p_ov  = (a[W-1] == bb[W-1]) && (p_s[W-1] != a[W-1]);
                m_rem = W + 1;
            end
        end else begin
            m_rem--;
            if (m_rem == 1) begin
                m_s    = p_s;
                m_co   = p_co;
                m_ov   = p_ov;
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("s", {24'd0, s}, {24'd0, m_s});
            chk("co", {31'd0, co}, {31'd0, m_co});
`ifdef SERIAL_ADDER_SUB_EN
            chk("ov", {31'd0, ov}, {31'd0, m_ov});
`endif
        end
    end

    // Issues one operation and waits (bounded) for done.
    // Returns with the bench sitting in the done cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tci, input logic tsub, output int nbusy);
        int  guard;
        bit  seen;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        ci    = tci;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = tsub;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        seen  = 1'b0;
        guard = 0;
        while (!seen && guard < 40) begin
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (tsub) begin
            // tsub is meaningful only when the subtract feature is built in.
        end
    endtask

    initial begin
        int nb;
        int ndone;
        logic [W-1:0] cap_s;
        logic cap_co;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_s", {24'd0, s}, 32'd0);
        chk("rst_co", {31'd0, co}, 32'd0);

        // 0F + 01: busy for 9 cycles, result 10 with no carry.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, nb);
        chk("lat_busy_cycles", nb, 32'd9);
        chk("lit_0f_s", {24'd0, s}, 32'h10);
        chk("lit_0f_co", {31'd0, co}, 32'd0);

        // FF + 01 + 1: wraps to 01 with carry out; result must hold afterwards.
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, nb);
        chk("lit_ff_s", {24'd0, s}, 32'h01);
        chk("lit_ff_co", {31'd0, co}, 32'd1);
        repeat (4) @(negedge clk);
        chk("hold_s", {24'd0, s}, 32'h01);
        chk("hold_co", {31'd0, co}, 32'd1);

        // start held high for a whole op while the operands keep changing.
        // Only the first latched operands (3C + A5 = E1) may count.
        a     = 8'h3C;
        b     = 8'hA5;
        ci    = 1'b0;
        start = 1'b1;
        ndone = 0;
        cap_s = '0;
        cap_co = 1'b0;
        for (int i = 0; i <= W + 3; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap_s  = s;
                cap_co = co;
            end
            if (i < W) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (i == W) start = 1'b0;
        end
        chk("held_start_ndone", ndone, 32'd1);
        chk("held_start_s", {24'd0, cap_s}, 32'hE1);
        chk("held_start_co", {31'd0, cap_co}, 32'd0);

        // Reset while SHIFT is at count=3: the op is aborted with no done,
        // and the next op still works.
        @(negedge clk);
        a     = 8'h77;
        b     = 8'h99;
        ci    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_s", {24'd0, s}, 32'd0);
        chk("midrst_co", {31'd0, co}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, done}, 32'd0);
        end
        run_op(8'h12, 8'h34, 1'b1, 1'b0, nb);
        chk("after_rst_s", {24'd0, s}, 32'h47);
        chk("after_rst_co", {31'd0, co}, 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        // 05 - 07 = FE with no carry and no overflow.
        run_op(8'h05, 8'h07, 1'b0, 1'b1, nb);
        chk("sub1_s", {24'd0, s}, 32'hFE);
        chk("sub1_co", {31'd0, co}, 32'd0);
        chk("sub1_ov", {31'd0, ov}, 32'd0);
        // 80 - 01 = 7F with carry and signed overflow.
        run_op(8'h80, 8'h01, 1'b0, 1'b1, nb);
        chk("sub2_s", {24'd0, s}, 32'h7F);
        chk("sub2_co", {31'd0, co}, 32'd1);
        chk("sub2_ov", {31'd0, ov}, 32'd1);
`endif

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            ci    = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub   = 1'($urandom);
`endif
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
